// File: rtl/kernel_pkg.sv
// Shared constants, state encoding and window packing for the kernel window sequencer.
package kernel_pkg;

  localparam int H_PIX_DEF   = 320;
  localparam int V_PIX_DEF   = 240;
  localparam int RD_LAT_DEF  = 2;
  localparam int BANK_AW_DEF = 15;

  localparam int WIN_CENTER  = 4;
  localparam int WIN_TOP_LSB = 6;
  localparam int WIN_MID_LSB = 3;
  localparam int WIN_BOT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Columns are {top,mid,bot}; window rows are {L,C,R} with L at the MSB.
  function automatic logic [8:0] make_win(input logic [2:0] l, input logic [2:0] c,
                                          input logic [2:0] r);
    return {l[2], c[2], r[2], l[1], c[1], r[1], l[0], c[0], r[0]};
  endfunction

endpackage

// File: rtl/kernel_window_sequencer_col_fifo.sv
// Small column FIFO between bank returns and the window assembler; its count feeds issue credits.
module col_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign dout   = mem_q[rd_q];
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)   wr_q <= ptr_inc(wr_q);
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/kernel_window_sequencer.sv
// Reads the three row-interleaved mask banks column by column and emits 3x3 edge-replicated windows.
// Row flow: IDLE -> WAIT -> ISSUE -> DRAIN -> (WAIT | DONE) -> IDLE.
module kernel_window_sequencer
  import kernel_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_PIX   = V_PIX_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int BANK_AW = BANK_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rows_written,
  output logic               rd_en_a,
  output logic               rd_en_b,
  output logic               rd_en_c,
  output logic [BANK_AW-1:0] rd_addr_a,
  output logic [BANK_AW-1:0] rd_addr_b,
  output logic [BANK_AW-1:0] rd_addr_c,
  input  logic               dout_a,
  input  logic               dout_b,
  input  logic               dout_c,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [8:0]         win,
  output logic [8:0]         win_x,
  output logic [7:0]         win_y,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);

  seq_state_e         state_q;
  logic [7:0]         y_q;
  logic [1:0]         ymid_q;
  logic [8:0]         ix_q;
  logic [BANK_AW-1:0] base_q    [3];
  logic [2:0]         rd_en_q;
  logic [BANK_AW-1:0] rd_addr_q [3];
  logic               busy_q, done_q;

  logic               iss_q;
  logic [RD_LAT-1:0]  vp_q;
  logic [2:0]         l_q, c_q;
  logic [8:0]         ax_q;
  logic               tail_q;
  logic               win_valid_q;
  logic [8:0]         win_q, win_x_q;
  logic [7:0]         win_y_q;

  logic [1:0]         ytop, ybot;
  logic               readable, credit_ok, issue_ok, last_accept;
  logic [2:0]         dout_v, col_in;
  logic               mid_bit;
  logic               push, out_free, fifo_pop, emit;
  logic [2:0]         fifo_dout;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  int                 need, occ;

  always_comb begin
    ytop = (ymid_q == 2'd0) ? 2'd2 : ymid_q - 2'd1;
    ybot = (ymid_q == 2'd2) ? 2'd0 : ymid_q + 2'd1;
    need = (int'(y_q) + 2 > V_PIX) ? V_PIX : int'(y_q) + 2;
    readable = int'(rows_written) >= need;
  end

  // Occupancy covers reads still in the bank pipe as well as columns already queued.
  always_comb begin
    occ = int'(fifo_count) + int'(iss_q);
    for (int i = 0; i < RD_LAT; i++) occ += int'(vp_q[i]);
    credit_ok = (occ - int'(fifo_pop)) < DEPTH;
    issue_ok  = credit_ok && ((state_q == ST_ISSUE) ||
                              (state_q == ST_WAIT && readable) ||
                              (state_q == ST_IDLE && start && readable));
  end

  assign last_accept = win_valid_q && win_ready && (win_x_q == 9'(H_PIX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      ymid_q  <= '0;
      ix_q    <= '0;
      rd_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        base_q[k]    <= '0;
        rd_addr_q[k] <= '0;
      end
    end else begin
      rd_en_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (last_accept) begin
            if (y_q == 8'(V_PIX - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              y_q     <= y_q + 8'd1;
              ymid_q  <= ybot;
              // The bank leaving the top slot becomes the new bottom, one bank row further down.
              if (y_q != '0) base_q[ytop] <= base_q[ytop] + BANK_AW'(H_PIX);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          y_q     <= '0;
          ymid_q  <= '0;
          for (int k = 0; k < 3; k++) base_q[k] <= '0;
        end
        default: ;
      endcase
      if (issue_ok) begin
        rd_en_q[ymid_q] <= 1'b1;
        rd_en_q[ytop]   <= (y_q != '0);
        rd_en_q[ybot]   <= (y_q != 8'(V_PIX - 1));
        for (int k = 0; k < 3; k++) rd_addr_q[k] <= base_q[k] + BANK_AW'(ix_q);
        if (ix_q == 9'(H_PIX - 1)) begin
          ix_q    <= '0;
          state_q <= ST_DRAIN;
        end else begin
          ix_q    <= ix_q + 9'd1;
          state_q <= ST_ISSUE;
        end
      end
    end
  end

  always_comb begin
    dout_v  = {dout_c, dout_b, dout_a};
    mid_bit = dout_v[ymid_q];
    col_in  = {(y_q == '0) ? mid_bit : dout_v[ytop],
               mid_bit,
               (y_q == 8'(V_PIX - 1)) ? mid_bit : dout_v[ybot]};
  end

  assign push     = vp_q[RD_LAT-1];
  assign out_free = !win_valid_q || win_ready;
  assign fifo_pop = !fifo_empty && !tail_q && ((ax_q == '0) || out_free);
  assign emit     = (fifo_pop && (ax_q != '0)) || (tail_q && out_free);

  col_fifo #(.DEPTH(DEPTH), .W(3)) u_col_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (col_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_q       <= 1'b0;
      vp_q        <= '0;
      l_q         <= '0;
      c_q         <= '0;
      ax_q        <= '0;
      tail_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      iss_q <= issue_ok;
      vp_q  <= (vp_q << 1) | RD_LAT'(iss_q);
      if (emit) begin
        win_valid_q <= 1'b1;
        win_y_q     <= y_q;
        if (tail_q) begin
          win_q   <= make_win(l_q, c_q, c_q);
          win_x_q <= 9'(H_PIX - 1);
        end else begin
          win_q   <= make_win(l_q, c_q, fifo_dout);
          win_x_q <= ax_q - 9'd1;
        end
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
      if (tail_q && out_free) tail_q <= 1'b0;
      if (fifo_pop) begin
        l_q <= (ax_q == '0) ? fifo_dout : c_q;
        c_q <= fifo_dout;
        if (ax_q == 9'(H_PIX - 1)) begin
          ax_q   <= '0;
          tail_q <= 1'b1;
        end else begin
          ax_q <= ax_q + 9'd1;
        end
      end
    end
  end

  assign rd_en_a   = rd_en_q[0];
  assign rd_en_b   = rd_en_q[1];
  assign rd_en_c   = rd_en_q[2];
  assign rd_addr_a = rd_addr_q[0];
  assign rd_addr_b = rd_addr_q[1];
  assign rd_addr_c = rd_addr_q[2];
  assign win_valid = win_valid_q;
  assign win       = win_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// Scoreboard bench: expected windows come from a clamped-neighbourhood model of the mask.
module tb_kernel_window_sequencer;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int RL = 2;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset, start, win_ready;
  logic [7:0]    rows_written;
  logic          rd_en_a, rd_en_b, rd_en_c;
  logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic          dout_a, dout_b, dout_c;
  logic          win_valid, busy, done;
  logic [8:0]    win, win_x;
  logic [7:0]    win_y;

  always #5 clk = ~clk;

  kernel_window_sequencer #(.H_PIX(H), .V_PIX(V), .RD_LAT(RL), .BANK_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rows_written(rows_written),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_en_c(rd_en_c),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c),
    .win_valid(win_valid), .win_ready(win_ready), .win(win), .win_x(win_x), .win_y(win_y),
    .busy(busy), .done(done)
  );

  typedef struct {
    int         x;
    int         y;
    logic [8:0] w;
  } exp_t;

  bit          mask [V][H];
  logic [8:0]  got  [V][H];
  exp_t        exp_q [$];
  int          checks = 0, errors = 0;
  int          done_cnt = 0, acc_cnt = 0, rd_cnt = 0, wv_cnt = 0;
  int          ready_mode = 0;
  bit          chk_done = 0, hold_prev = 0;
  logic [8:0]  prev_win, prev_x;
  logic [7:0]  prev_y;

  logic [2:0]    rden;
  logic [AW-1:0] raddr [3];
  logic [RL-1:0] bpipe [3];
  assign rden     = {rd_en_c, rd_en_b, rd_en_a};
  assign raddr[0] = rd_addr_a;
  assign raddr[1] = rd_addr_b;
  assign raddr[2] = rd_addr_c;
  assign dout_a   = bpipe[0][RL-1];
  assign dout_b   = bpipe[1][RL-1];
  assign dout_c   = bpipe[2][RL-1];

  function automatic bit bank_bit(input int k, input int a);
    int r, c;
    r = 3 * (a / H) + k;
    c = a % H;
    if (r >= V) return 1'b0;
    return mask[r][c];
  endfunction

  // Bank model: registered read with RL cycles from strobe to data; junk when not strobed.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      bpipe[k] <= {bpipe[k][RL-2:0],
                   rden[k] ? bank_bit(k, int'(raddr[k])) : 1'($urandom_range(0, 1))};
  end

  function automatic int clampi(input int v, input int n);
    if (v < 0) return 0;
    if (v >= n) return n - 1;
    return v;
  endfunction

  function automatic logic [8:0] exp_win(input int x, input int y);
    logic [8:0] w;
    int yy, xx;
    w = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        yy = clampi(y + dy, V);
        xx = clampi(x + dx, H);
        w[8 - ((dy + 1) * 3 + (dx + 1))] = mask[yy][xx];
      end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever a window is accepted, plus protocol checks.
  always @(negedge clk) begin
    exp_t e;
    int   r;
    if (reset) begin
      hold_prev = 0;
      chk_done  = 0;
    end else begin
      if (chk_done) begin
        chk_done = 0;
        chk("done_pulse", {30'd0, done, busy}, 32'h2);
      end else if (done) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end
      if (done) done_cnt++;
      for (int k = 0; k < 3; k++)
        if (rden[k]) begin
          r = 3 * (int'(raddr[k]) / H) + k;
          chk("read_row_written", 32'(r < int'(rows_written)), 32'h1);
        end
      if (|rden) rd_cnt++;
      if (win_valid) wv_cnt++;
      if (hold_prev)
        chk("hold_stable", {win_valid, win_y, win_x, win}, {1'b1, prev_y, prev_x, prev_win});
      hold_prev = win_valid && !win_ready;
      prev_win  = win;
      prev_x    = win_x;
      prev_y    = win_y;
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_window", {5'd0, win_y, win_x, 1'b0, win}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("window", {5'd0, win_y, win_x, 1'b0, win},
              {5'd0, 8'(e.y), 9'(e.x), 1'b0, e.w});
          got[e.y][e.x] = win;
          acc_cnt++;
          if (e.x == H - 1 && e.y == V - 1) chk_done = 1;
        end
      end
    end
  end

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      win_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  task automatic clear_mask();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) mask[y][x] = 1'b0;
  endtask

  task automatic random_mask();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) mask[y][x] = ($urandom_range(0, 99) < 40);
  endtask

  task automatic push_expect();
    exp_t e;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        got[y][x] = 9'h1FF;
        e.x = x;
        e.y = y;
        e.w = exp_win(x, y);
        exp_q.push_back(e);
      end
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0, input int limit);
    int n;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt != d0), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic run_frame(input string nm);
    int d0;
    repeat (3) @(posedge clk);
    push_expect();
    d0 = done_cnt;
    start_pulse();
    wait_done(nm, d0, 5000);
  endtask

  task automatic wait_acc(input string nm, input int target, input int limit);
    int n;
    n = 0;
    while (acc_cnt < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_reached"}, 32'(acc_cnt >= target), 32'h1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nz, d0, a0, r0, w0, n;
    reset = 1'b1;
    start = 1'b0;
    rows_written = 8'(V);
    clear_mask();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, win_valid, rden, win}, 32'h0);
    chk("reset_coords", {win_y, win_x}, 32'h0);
    chk("reset_addrs", {rd_addr_a, rd_addr_b}, 32'h0);
    chk("reset_addr_c", 32'(rd_addr_c), 32'h0);
    reset = 1'b0;

    clear_mask();
    mask[5][5] = 1'b1;
    run_frame("pix55");
    chk("pix55_centre", 32'(got[5][5]), 32'b000_010_000);
    chk("pix55_diag", 32'(got[4][4]), 32'b000_000_001);
    nz = 0;
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) if (got[y][x] != 9'd0) nz++;
    chk("pix55_nonzero", 32'(nz), 32'd9);

    clear_mask();
    mask[0][0] = 1'b1;
    run_frame("pix00");
    chk("pix00_corner", 32'(got[0][0]), 32'b110_110_000);

    clear_mask();
    mask[V-1][H-1] = 1'b1;
    run_frame("pixlast");
    chk("pixlast_corner", 32'(got[V-1][H-1]), 32'b000_011_011);

    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      random_mask();
      run_frame("random");
    end

    ready_mode = 0;
    random_mask();
    rows_written = 8'd1;
    repeat (3) @(posedge clk);
    push_expect();
    d0 = done_cnt;
    a0 = acc_cnt;
    start_pulse();
    r0 = rd_cnt;
    w0 = wv_cnt;
    repeat (40) @(posedge clk);
    chk("hold1_no_reads", 32'(rd_cnt - r0), 32'h0);
    chk("hold1_no_windows", 32'(wv_cnt - w0), 32'h0);
    #1 rows_written = 8'd2;
    wait_acc("row0", a0 + H, 500);
    start_pulse();
    repeat (40) @(posedge clk);
    chk("hold2_stall", 32'(acc_cnt - a0), 32'(H));
    #1 rows_written = 8'd3;
    wait_acc("row1", a0 + 2 * H, 500);
    repeat (40) @(posedge clk);
    chk("hold3_stall", 32'(acc_cnt - a0), 32'(2 * H));
    #1 rows_written = 8'(V);
    wait_done("hold", d0, 5000);

    ready_mode = 1;
    random_mask();
    repeat (3) @(posedge clk);
    push_expect();
    start_pulse();
    n = 0;
    @(negedge clk);
    while (!(win_valid && win_x == 9'd8 && win_y == 8'd6) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("centre_reached", 32'(win_valid && win_x == 9'd8 && win_y == 8'd6), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_outputs", {busy, done, win_valid, rden}, 32'h0);
    reset = 1'b0;
    random_mask();
    run_frame("after_reset");
    chk("after_reset_origin", 32'(got[0][0]), 32'(exp_win(0, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
